// File: rtl/twod_counter_pipe.sv
// twod_counter_pipe: WIDTH-bit event counter split into STAGES digit stages.
// Carries ripple one stage per clock, so a new increment can be taken every
// cycle while earlier carries are still travelling up the digit chain. A carry
// out of the top digit is held in ovf until the consumer takes it. While ovf
// is waiting, the whole wavefront freezes.
module twod_counter_pipe #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             init,
  input  logic             inc_valid,
  output logic             inc_ready,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             settled,
  output logic             ovf_valid,
  input  logic             ovf_ready
);

  localparam int STAGES = WIDTH / DIGIT;

  // Digit registers, stage 0 in the least significant position.
  logic [STAGES-1:0][DIGIT-1:0] digit;
  logic [STAGES-1:0][DIGIT-1:0] digit_nxt;
  // carry[i] is the carry waiting to enter stage i. Stage 0 takes its carry
  // from an accepted increment, so carry[0] is always held at zero.
  logic [STAGES-1:0]            carry;
  logic [STAGES-1:0]            cin;
  logic [STAGES-1:0]            cout;
  logic                         ovf;
  logic                         stall;
  logic                         load_fire;
  logic                         inc_fire;

  // Handshake control: a pending overflow that is not being taken freezes
  // everything. A load is taken only when no carry is in flight, and it wins
  // over an increment in the same cycle.
  always_comb begin
    stall      = ovf & ~ovf_ready;
    settled    = ~|carry;
    load_ready = ~init & ~stall & settled;
    load_fire  = load_valid & load_ready;
    inc_ready  = ~init & ~stall & ~load_fire;
    inc_fire   = inc_valid & inc_ready;
  end

  // Per-stage add of the incoming carry and detection of the outgoing carry.
  always_comb begin
    cin       = carry;
    cin[0]    = inc_fire;
    cout      = '0;
    digit_nxt = digit;
    for (int i = 0; i < STAGES; i++) begin
      cout[i]      = cin[i] & (&digit[i]);
      digit_nxt[i] = digit[i] + DIGIT'(cin[i]);
    end
  end

  // State update: init clears everything. A stall freezes digits, carries
  // and ovf. Otherwise the wavefront advances by one stage, or a load
  // replaces the digits. The carries are already all zero when a load is
  // accepted, so they stay zero.
  always_ff @(posedge clk) begin
    if (init) begin
      digit <= '0;
      carry <= '0;
      ovf   <= 1'b0;
    end else if (!stall) begin
      if (load_fire) begin
        digit <= load_value;
      end else begin
        digit <= digit_nxt;
      end
      carry[0] <= 1'b0;
      for (int i = 1; i < STAGES; i++) begin
        carry[i] <= cout[i-1];
      end
      // A new top carry keeps ovf set even if the consumer takes the old one
      // on the same edge. When not stalled with ovf set, ovf_ready is high,
      // so clearing here completes the handshake.
      if (cout[STAGES-1]) begin
        ovf <= 1'b1;
      end else if (ovf_ready) begin
        ovf <= 1'b0;
      end
    end
  end

  assign count     = digit;
  assign ovf_valid = ovf;

endmodule
